// File: rtl/instr_prefetch_queue_if.sv
// instr_prefetch_queue_if: memory read bus plus instruction valid/ready handshake
interface instr_prefetch_queue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_data;
    logic              mem_mfc;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    modport master (
        output mem_addr, mem_en, mem_rw, instr, instr_pc, instr_valid,
        input  mem_data, mem_mfc, instr_ready
    );
    modport slave (
        input  mem_addr, mem_en, mem_rw, instr, instr_pc, instr_valid,
        output mem_data, mem_mfc, instr_ready
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction fetch into a FIFO with flush/redirect and MFC timeout fault
module instr_prefetch_queue #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 4,
    parameter int MFC_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    pc_load,
    input  logic [ADDR_W-1:0]       pc_value,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    fault,
    instr_prefetch_queue_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(MFC_TIMEOUT + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(MFC_TIMEOUT - 1);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FAULT} state_t;
    state_t            state, state_nx;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [TW-1:0]     wait_cnt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     count_nx;
    logic              push, pop;
    // a redirect discards the in-flight response and any pop in the same cycle
    assign push     = state == S_WAIT && bus.mem_mfc && !pc_load;
    assign pop      = bus.instr_valid && bus.instr_ready && !pc_load;
    assign count_nx = fifo_count + CW'(push) - CW'(pop);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = (start && fifo_count < FULL) ? S_REQ : S_IDLE;
            S_REQ:   state_nx = S_WAIT;
            S_WAIT:  state_nx = bus.mem_mfc ? ((start && count_nx < FULL) ? S_REQ : S_IDLE)
                                            : (wait_cnt == TLAST ? S_FAULT : S_WAIT);
            default: state_nx = S_FAULT;
        endcase
        if (pc_load) state_nx = S_IDLE;
    end
    always_comb begin
        bus.mem_en      = state == S_REQ || state == S_WAIT;
        bus.mem_rw      = state == S_REQ || state == S_WAIT;
        bus.mem_addr    = fetch_pc;
        bus.instr       = data_q[rd_ptr];
        bus.instr_pc    = pc_q[rd_ptr];
        bus.instr_valid = fifo_count != '0;
        fault           = state == S_FAULT;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            wait_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (pc_load) begin
            fetch_pc   <= pc_value;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            wait_cnt   <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= bus.mem_data;
                pc_q[wr_ptr]   <= fetch_pc;
                wr_ptr         <= wr_ptr + AW'(1);
                fetch_pc       <= fetch_pc + ADDR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= count_nx;
            wait_cnt   <= state == S_REQ ? '0 : (state == S_WAIT && !bus.mem_mfc) ? wait_cnt + TW'(1) : wait_cnt;
        end
    end
endmodule
